// File: rtl/hmm_pkg.sv
// Shared HMM scoring constants and the Q5.6 score type used by the
// likelihood stage and the Viterbi decoder.
package hmm_pkg;
  localparam int IBIT      = 11;
  localparam int OBIT      = 12;
  localparam int LFBIT     = 6;
  localparam int IDIM      = 42;
  localparam int IDXW      = 6;
  localparam int LOG_FLOOR = -1024;

  typedef logic signed [OBIT-1:0] score_t;
  typedef logic [IDXW-1:0]        idx_t;

  // round(64 * log2(1 + k/32)), k = 0..31
  localparam int LOG2_LUT [32] = '{
     0,  3,  6,  8, 11, 13, 16, 18, 21, 23, 25, 27, 29, 31, 34, 35,
    37, 39, 41, 43, 45, 47, 48, 50, 52, 53, 55, 56, 58, 60, 61, 63
  };

  function automatic score_t sat_score(input logic signed [OBIT:0] v);
    if (v[OBIT] != v[OBIT-1])
      return v[OBIT] ? {1'b1, {(OBIT-1){1'b0}}} : {1'b0, {(OBIT-1){1'b1}}};
    return v[OBIT-1:0];
  endfunction
endpackage

// File: rtl/softmax_loglik_if.sv
// Posterior-in / score-out bundle between the softmax stage, this block and
// the Viterbi decoder, plus the prior-table write port.
interface softmax_loglik_if;
  import hmm_pkg::*;

  logic            dv_in;
  logic [IBIT-1:0] sofin;
  logic            prior_we;
  logic [6:0]      prior_addr;
  score_t          prior_data;
  logic            dv_out;
  score_t          llout;
  logic            frame_done;
  logic [6:0]      max_idx;
  logic            frame_err;

  modport master (
    output dv_in, sofin, prior_we, prior_addr, prior_data,
    input  dv_out, llout, frame_done, max_idx, frame_err
  );

  modport slave (
    input  dv_in, sofin, prior_we, prior_addr, prior_data,
    output dv_out, llout, frame_done, max_idx, frame_err
  );
endinterface

// File: rtl/log2_q6.sv
// Two-stage fixed-point log2 of an unsigned Q1.10 value, result in Q5.6:
// stage 1 priority-encodes the exponent, stage 2 looks up the mantissa.
module log2_q6
  import hmm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [IBIT-1:0] x_i,
  output score_t          l_o
);
  logic       z_q, z_d;
  logic [3:0] m_q, m_d;
  logic [4:0] f_q, f_d;
  score_t     l_q, l_d;

  always_comb begin
    z_d = (x_i == '0);
    m_d = 4'd0;
    for (int i = 0; i < IBIT - 1; i++)
      if (x_i[i]) m_d = 4'(i);
    // Values above 1.0 pin the exponent at 0 and take the mantissa from bits 9:5.
    if (x_i[IBIT-1]) m_d = 4'd10;
    f_d = 5'((x_i << (4'd10 - m_d)) >> 5);
  end

  always_comb begin
    l_d = score_t'(LOG_FLOOR);
    if (!z_q) l_d = score_t'(((int'(m_q) - 10) <<< LFBIT) + LOG2_LUT[f_q]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= 1'b0;
      m_q <= '0;
      f_q <= '0;
      l_q <= '0;
    end else begin
      z_q <= z_d;
      m_q <= m_d;
      f_q <= f_d;
      l_q <= l_d;
    end
  end

  assign l_o = l_q;
endmodule

// File: rtl/softmax_loglik.sv
// Posterior-to-log-likelihood converter: 3-cycle score pipeline plus per-frame argmax.
// Build option: define PRIOR_SUB_EN to enable the per-state log2 prior table.
module softmax_loglik
  import hmm_pkg::*;
(
  input logic             clk,
  input logic             rst,
  softmax_loglik_if.slave bus
);
  localparam idx_t IDX_LAST = idx_t'(IDIM - 1);

  idx_t   idx_q, idx_d, idx1_q, idx2_q, idx3_q;
  logic   v1_q, v2_q, dv_out_q;
  logic   frame_err_q, frame_err_d;
  logic   frame_done_q, last_out;
  score_t l2, s_d, llout_q, run_max_q;
  idx_t   run_idx_q, max_idx_q;

  log2_q6 u_log2 (
    .clk (clk),
    .rst (rst),
    .x_i (bus.sofin),
    .l_o (l2)
  );

  always_comb begin
    idx_d       = idx_q;
    frame_err_d = 1'b0;
    if (bus.dv_in) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + idx_t'(1);
    end else if (idx_q != '0) begin
      idx_d       = '0;
      frame_err_d = 1'b1;
    end
  end

`ifdef PRIOR_SUB_EN
  score_t prior_q [IDIM];

  // Read is combinational off the registered table, so a same-cycle write is not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IDIM; i++) prior_q[i] <= '0;
    end else if (bus.prior_we && (bus.prior_addr < 7'(IDIM))) begin
      prior_q[bus.prior_addr[IDXW-1:0]] <= bus.prior_data;
    end
  end

  assign s_d = sat_score({l2[OBIT-1], l2} - {prior_q[idx2_q][OBIT-1], prior_q[idx2_q]});
`else
  logic unused_prior;
  assign unused_prior = ^{bus.prior_we, bus.prior_addr, bus.prior_data};
  assign s_d          = l2;
`endif

  assign last_out = dv_out_q && (idx3_q == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      idx1_q       <= '0;
      idx2_q       <= '0;
      idx3_q       <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      dv_out_q     <= 1'b0;
      llout_q      <= '0;
      run_max_q    <= '0;
      run_idx_q    <= '0;
      frame_done_q <= 1'b0;
      max_idx_q    <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      frame_err_q <= frame_err_d;
      v1_q        <= bus.dv_in;
      idx1_q      <= idx_q;
      v2_q        <= v1_q;
      idx2_q      <= idx1_q;
      dv_out_q    <= v2_q;
      idx3_q      <= idx2_q;
      llout_q     <= v2_q ? s_d : '0;
      // Strict compare keeps the lowest index on ties.
      if (v2_q && ((idx2_q == '0) || (s_d > run_max_q))) begin
        run_max_q <= s_d;
        run_idx_q <= idx2_q;
      end
      frame_done_q <= last_out;
      if (last_out) max_idx_q <= run_idx_q;
    end
  end

  assign bus.dv_out     = dv_out_q;
  assign bus.llout      = llout_q;
  assign bus.frame_done = frame_done_q;
  assign bus.max_idx    = {1'b0, max_idx_q};
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_softmax_loglik.sv
// Directed bench for softmax_loglik with a scoreboard for scores, frame_done and frame_err.
module tb_softmax_loglik;
  import hmm_pkg::*;

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t fd_q[$];
  exp_t err_q[$];
  int   prior_m [IDIM];
  int   m_idx, m_run, m_run_idx, cur_max;

  softmax_loglik_if bus ();

  softmax_loglik dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model_l(input int x);
    int m = 0;
    int f;
    int lut;
    if (x == 0) return LOG_FLOOR;
    for (int i = 0; i < 11; i++) if (((x >> i) & 1) != 0) m = i;
    f   = ((x << (10 - m)) >> 5) & 31;
    lut = $rtoi(64.0 * $ln(1.0 + real'(f) / 32.0) / $ln(2.0) + 0.5);
    return (m - 10) * 64 + lut;
  endfunction

  function automatic int model_sat(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.dv_out === 1'b1) begin
      check("out_expected", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("llout", $signed(bus.llout), e.val);
        check("out_cycle", cyc, e.due);
      end
    end else begin
      check("llout_idle", $signed(bus.llout), 0);
      check("out_missing", (sb_q.size() > 0) && (sb_q[0].due <= cyc), 0);
      if ((sb_q.size() > 0) && (sb_q[0].due <= cyc)) void'(sb_q.pop_front());
    end

    if (bus.frame_done === 1'b1) begin
      check("fd_expected", (fd_q.size() > 0) && (fd_q[0].due == cyc), 1);
      if (fd_q.size() > 0) begin
        e = fd_q.pop_front();
        check("max_idx", bus.max_idx, e.val);
        cur_max = e.val;
      end
    end else begin
      check("fd_missing", (fd_q.size() > 0) && (fd_q[0].due <= cyc), 0);
      if ((fd_q.size() > 0) && (fd_q[0].due <= cyc)) void'(fd_q.pop_front());
    end

    if (bus.frame_err === 1'b1) begin
      check("err_expected", (err_q.size() > 0) && (err_q[0].due == cyc), 1);
      check("max_idx_hold", bus.max_idx, cur_max);
      if (err_q.size() > 0) void'(err_q.pop_front());
    end else begin
      check("err_missing", (err_q.size() > 0) && (err_q[0].due <= cyc), 0);
      if ((err_q.size() > 0) && (err_q[0].due <= cyc)) void'(err_q.pop_front());
    end
  end

  task automatic send(input int x);
    int s;
    @(posedge clk); #1;
    bus.dv_in = 1'b1;
    bus.sofin = 11'(x);
    s = model_sat(model_l(x) - prior_m[m_idx]);
    sb_q.push_back('{s, cyc + 3});
    if ((m_idx == 0) || (s > m_run)) begin
      m_run     = s;
      m_run_idx = m_idx;
    end
    if (m_idx == IDIM - 1) begin
      fd_q.push_back('{m_run_idx, cyc + 4});
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.dv_in = 1'b0;
      bus.sofin = '0;
      if (m_idx != 0) begin
        err_q.push_back('{0, cyc + 1});
        m_idx = 0;
      end
    end
  endtask

  task automatic wr_prior(input int a, input int d);
    @(posedge clk); #1;
    bus.prior_we   = 1'b1;
    bus.prior_addr = 7'(a);
    bus.prior_data = 12'(d);
`ifdef PRIOR_SUB_EN
    if (a < IDIM) prior_m[a] = d;
`endif
    @(posedge clk); #1;
    bus.prior_we = 1'b0;
  endtask

  task automatic flush(input int now);
    while ((sb_q.size() > 0) && (sb_q[$].due > now)) void'(sb_q.pop_back());
    while ((fd_q.size() > 0) && (fd_q[$].due > now)) void'(fd_q.pop_back());
    while ((err_q.size() > 0) && (err_q[$].due > now)) void'(err_q.pop_back());
  endtask

  task automatic frame_basic();
    send(1024);
    send(512);
    send(768);
    send(1);
    for (int i = 4; i < IDIM; i++) send(0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dv_out"}, bus.dv_out, 0);
    check({tag, "_llout"}, $signed(bus.llout), 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_max_idx"}, bus.max_idx, 0);
    check({tag, "_frame_err"}, bus.frame_err, 0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.dv_in      = 1'b0;
    bus.sofin      = '0;
    bus.prior_we   = 1'b0;
    bus.prior_addr = '0;
    bus.prior_data = '0;
    m_idx          = 0;
    m_run          = 0;
    m_run_idx      = 0;
    cur_max        = 0;
    for (int i = 0; i < IDIM; i++) prior_m[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("init");
    rst = 1'b0;

    frame_basic();
    idle(6);

    for (int i = 0; i < IDIM; i++) send(((i == 3) || (i == 7)) ? 256 : 1);
    idle(4);

    for (int i = 0; i < 20; i++) send(int'($urandom_range(1024, 0)));
    idle(6);
    for (int i = 0; i < IDIM; i++) send(int'($urandom_range(1024, 0)));
    idle(6);

    for (int i = 0; i < 2 * IDIM; i++) send(int'($urandom_range(1024, 1)));
    idle(6);

    wr_prior(5, -128);
    for (int i = 0; i < IDIM; i++) send((i == 5) ? 1024 : 512);
    idle(6);

    wr_prior(0, -2048);
    wr_prior(1, 2047);
    wr_prior(50, 100);
    send(1024);
    send(0);
    for (int i = 2; i < IDIM; i++) send(int'($urandom_range(2047, 0)));
    idle(6);

    for (int i = 0; i < 10; i++) send(int'($urandom_range(1024, 0)));
    @(posedge clk); #1;
    rst       = 1'b1;
    bus.dv_in = 1'b0;
    flush(cyc);
    m_idx   = 0;
    cur_max = 0;
    for (int i = 0; i < IDIM; i++) prior_m[i] = 0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;

    frame_basic();
    idle(8);

    check("sb_drained", sb_q.size(), 0);
    check("fd_drained", fd_q.size(), 0);
    check("err_drained", err_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
